// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters.
// Ownership lasts a full CYC; a per-transfer watchdog aborts a stalled slave with ERR.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_w,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic [DATA_WIDTH-1:0]             m_dat_r,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_dat_w,
  input  logic [DATA_WIDTH-1:0]             s_dat_r,
  input  logic                              s_ack,
  output logic [NUM_MASTERS-1:0]            grant
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t                 state, state_n;
  logic [NUM_MASTERS-1:0] grant_n;
  logic [IW-1:0]          owner, owner_n;
  logic [IW-1:0]          last, last_n;
  logic [WW-1:0]          wd_cnt, wd_n;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  // Scan starting just after the last owner, wrapping; first requester wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = last;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (idx == IW'(NUM_MASTERS - 1)) ? '0 : idx + IW'(1);
      if (m_cyc[idx] && !pick_valid) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Handshake: a beat completes on any cycle where s_stb and s_ack are both high;
  // STB without ACK is a stall, counted by the watchdog.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    if (state == BUSY) begin
      s_cyc   = m_cyc[owner];
      s_stb   = m_stb[owner];
      s_we    = m_we[owner];
      s_adr   = m_adr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_w = m_dat_w[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
    m_ack = (state == BUSY && s_stb && s_ack) ? grant : '0;
    m_err = (state == ABORT) ? grant : '0;
  end

  assign m_dat_r = s_dat_r;

  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    last_n  = last;
    wd_n    = wd_cnt;
    case (state)
      IDLE: begin
        wd_n = '0;
        if (pick_valid) begin
          state_n           = BUSY;
          owner_n           = pick_idx;
          grant_n           = '0;
          grant_n[pick_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (!m_cyc[owner]) begin
          state_n = IDLE;
          last_n  = owner;
          grant_n = '0;
          wd_n    = '0;
        end else if (s_stb && !s_ack) begin
          if (wd_cnt == WW'(TIMEOUT - 1)) begin
            state_n = ABORT;
            wd_n    = '0;
          end else begin
            wd_n = wd_cnt + WW'(1);
          end
        end else begin
          wd_n = '0;
        end
      end
      ABORT: begin
        state_n = IDLE;
        last_n  = owner;
        grant_n = '0;
        wd_n    = '0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        wd_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      last   <= IW'(NUM_MASTERS - 1);
      wd_cnt <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      owner  <= owner_n;
      last   <= last_n;
      wd_cnt <= wd_n;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table, directed multi-cycle sequences,
// then randomized traffic against a cycle-level reference model.
module tb_wb_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      m_cyc, m_stb, m_we;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_dat_w;
  logic [N-1:0]      m_ack, m_err;
  logic [DW-1:0]     m_dat_r;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_w;
  logic [DW-1:0]     s_dat_r;
  logic              s_ack;
  logic [N-1:0]      grant;

  int checks   = 0;
  int failures = 0;

  wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_w(m_dat_w),
    .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .grant(grant)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [N-1:0] c, input logic [N-1:0] s,
                       input logic [N-1:0] w, input logic a);
    @(negedge clk);
    reset = r;
    m_cyc = c;
    m_stb = s;
    m_we  = w;
    s_ack = a;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         rst;
    logic [N-1:0] cyc, stb, we;
    logic         ack;
    logic [N-1:0] e_grant;
    logic         e_scyc;
    logic [N-1:0] e_ack;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
  } vec_t;

  vec_t tbl[13];

  // ---------------- reference model state ----------------
  int mdl_owner, mdl_last, mdl_wd;
  bit mdl_abort;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  e_grant, e_ack, e_err, prev_ack, prev_err, req, prev_grant, got;
  logic          e_scyc, e_sstb, e_swe;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;

  logic [N-1:0] exp_g[12];
  logic         exp_c[12];
  logic [N-1:0] exp_e[12];
  logic [N-1:0] hold;

  initial begin
    reset = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_dat_r = '0;
    m_adr   = {16'h0040, 16'h1111};
    m_dat_w = {16'hBEEF, 16'h2222};
    @(posedge clk);

    // rst cyc stb we ack | grant scyc ack adr dat
    tbl[0]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 2'b10, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0000, 16'h0000};
    tbl[4]  = '{1'b1, 2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 2'b00, 16'h0040, 16'hBEEF};
    tbl[5]  = '{1'b1, 2'b10, 2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 2'b00, 16'h0040, 16'hBEEF};
    tbl[6]  = '{1'b1, 2'b10, 2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10, 16'h0040, 16'hBEEF};
    tbl[7]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 16'h0040, 16'hBEEF};
    tbl[8]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 16'h0000, 16'h0000};
    tbl[9]  = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 16'h0000, 16'h0000};
    tbl[10] = '{1'b1, 2'b01, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01, 16'h1111, 16'h2222};
    tbl[11] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 16'h1111, 16'h2222};
    tbl[12] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 16'h0000, 16'h0000};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].ack);
      check($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
      check($sformatf("tbl%0d_s_cyc", i), s_cyc, tbl[i].e_scyc);
      check($sformatf("tbl%0d_m_ack", i), m_ack, tbl[i].e_ack);
      check($sformatf("tbl%0d_m_err", i), m_err, '0);
      check($sformatf("tbl%0d_s_adr", i), s_adr, tbl[i].e_adr);
      check($sformatf("tbl%0d_s_dat_w", i), s_dat_w, tbl[i].e_dat);
    end

    // ---- contention: both masters always request, slave ACKs at once ----
    exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    do_reset();
    hold = '0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, ~hold, ~hold, '0, 1'b1);
      check($sformatf("contend%0d_grant", k), grant, exp_g[k]);
      hold = m_ack;
    end
    drive(1'b1, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, 1'b0);

    // ---- timeout: slave never ACKs, master 1 waits its turn ----
    exp_g = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
    exp_c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_e = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, (k < 10) ? 2'b11 : 2'b10, (k < 10) ? 2'b11 : 2'b10, '0, 1'b0);
      check($sformatf("tmo%0d_grant", k), grant, exp_g[k]);
      check($sformatf("tmo%0d_s_cyc", k), s_cyc, exp_c[k]);
      check($sformatf("tmo%0d_m_err", k), m_err, exp_e[k]);
      if (k == 9) check("tmo_s_stb", s_stb, 1'b0);
    end
    drive(1'b1, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, 1'b0);

    // ---- race: ACK on the cycle the watchdog would expire ----
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, (k < 9) ? 2'b01 : 2'b00, (k < 9) ? 2'b01 : 2'b00, '0, k == 8);
      check($sformatf("race%0d_m_ack", k), m_ack, (k == 8) ? 2'b01 : 2'b00);
      check($sformatf("race%0d_m_err", k), m_err, 2'b00);
      check($sformatf("race%0d_grant", k), grant, (k == 0 || k == 10) ? 2'b00 : 2'b01);
    end

    // ---- reset during a BUSY read ----
    do_reset();
    drive(1'b1, 2'b10, 2'b10, 2'b00, 1'b0);
    drive(1'b1, 2'b10, 2'b10, 2'b00, 1'b0);
    check("midrst_busy_grant", grant, 2'b10);
    check("midrst_busy_s_we", s_we, 1'b0);
    drive(1'b0, 2'b10, 2'b10, 2'b00, 1'b0);
    drive(1'b1, 2'b11, 2'b11, 2'b00, 1'b1);
    check("midrst_s_cyc", s_cyc, 1'b0);
    check("midrst_grant", grant, 2'b00);
    check("midrst_m_ack", m_ack, 2'b00);
    check("midrst_m_err", m_err, 2'b00);
    drive(1'b1, 2'b11, 2'b11, 2'b00, 1'b1);
    check("midrst_first_grant", grant, 2'b01);
    drive(1'b1, '0, '0, '0, 1'b0);
    drive(1'b1, '0, '0, '0, 1'b0);

    // ---- randomized traffic vs reference model ----
    do_reset();
    mdl_owner = -1; mdl_last = N - 1; mdl_wd = 0; mdl_abort = 0;
    req = '0; prev_ack = '0; prev_err = '0; prev_grant = '0;
    exp_q.delete();
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i] && (prev_ack[i] || prev_err[i])) req[i] = 1'b0;
        else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            m_we[i] = 1'($urandom_range(0, 1));
            m_adr[i*AW +: AW]   = AW'($urandom);
            m_dat_w[i*DW +: DW] = DW'($urandom);
          end
        end else if (mdl_owner != i && $urandom_range(0, 29) == 0) req[i] = 1'b0;
        m_cyc[i] = req[i];
        m_stb[i] = req[i] && ($urandom_range(0, 7) != 0);
      end
      s_ack   = ($urandom_range(0, 2) == 0);
      s_dat_r = DW'($urandom);
      reset   = ($urandom_range(0, 299) != 0);
      #1;
      e_grant = '0; e_ack = '0; e_err = '0;
      e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0; e_adr = '0; e_dat = '0;
      if (mdl_owner >= 0) begin
        e_grant[mdl_owner] = 1'b1;
        if (mdl_abort) e_err[mdl_owner] = 1'b1;
        else begin
          e_scyc = m_cyc[mdl_owner];
          e_sstb = m_stb[mdl_owner];
          e_swe  = m_we[mdl_owner];
          e_adr  = m_adr[mdl_owner*AW +: AW];
          e_dat  = m_dat_w[mdl_owner*DW +: DW];
          if (s_ack && e_sstb) e_ack[mdl_owner] = 1'b1;
        end
      end
      check("rnd_grant", grant, e_grant);
      check("rnd_m_ack", m_ack, e_ack);
      check("rnd_m_err", m_err, e_err);
      check("rnd_s_ctl", {s_cyc, s_stb, s_we}, {e_scyc, e_sstb, e_swe});
      check("rnd_s_adr", s_adr, e_adr);
      check("rnd_s_dat_w", s_dat_w, e_dat);
      check("rnd_m_dat_r", m_dat_r, s_dat_r);
      if (grant != '0 && prev_grant == '0) begin
        if (exp_q.size() == 0) check("rnd_grant_order_unexpected", grant, '0);
        else begin
          got = exp_q.pop_front();
          check("rnd_grant_order", grant, got);
        end
      end
      prev_grant = grant;
      prev_ack = e_ack;
      prev_err = e_err;
      @(posedge clk);
      if (!reset) begin
        mdl_owner = -1; mdl_last = N - 1; mdl_wd = 0; mdl_abort = 0;
      end else if (mdl_abort) begin
        mdl_last = mdl_owner; mdl_owner = -1; mdl_abort = 0;
      end else if (mdl_owner < 0) begin
        mdl_wd = 0;
        for (int k = 1; k <= N; k++) begin
          if (mdl_owner < 0 && m_cyc[(mdl_last + k) % N]) begin
            mdl_owner = (mdl_last + k) % N;
            exp_q.push_back(N'(1) << mdl_owner);
          end
        end
      end else if (!m_cyc[mdl_owner]) begin
        mdl_last = mdl_owner; mdl_owner = -1; mdl_wd = 0;
      end else if (m_stb[mdl_owner] && !s_ack) begin
        // abort on the TO-th consecutive stalled cycle
        mdl_wd++;
        if (mdl_wd == TO) begin
          mdl_abort = 1; mdl_wd = 0;
        end
      end else begin
        mdl_wd = 0;
      end
    end

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
